// File: rtl/alu_secuenciador_pkg.sv
// Shared state encoding and LED decode for the ALU operand-entry sequencer.
package alu_secuenciador_pkg;

  typedef enum logic [1:0] {CARGA_A, CARGA_B, CARGA_OP, MOSTRAR} estado_t;

  localparam logic [3:0] LED_CARGA_A  = 4'b0001;
  localparam logic [3:0] LED_CARGA_B  = 4'b0010;
  localparam logic [3:0] LED_CARGA_OP = 4'b0100;
  localparam logic [3:0] LED_MOSTRAR  = 4'b1000;

  function automatic logic [3:0] leds_de(input estado_t e);
    logic [3:0] r;
    r = LED_CARGA_A;
    case (e)
      CARGA_A:  r = LED_CARGA_A;
      CARGA_B:  r = LED_CARGA_B;
      CARGA_OP: r = LED_CARGA_OP;
      MOSTRAR:  r = LED_MOSTRAR;
      default:  r = LED_CARGA_A;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/antirrebote.sv
// Push-button conditioner: 2-flop synchronizer, debounce filter and a
// one-cycle pulse on each accepted press.
module antirrebote #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic boton,
  output logic pulso
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic          boton_p0, boton_p1;
  logic          nivel, nivel_p2;
  logic [CW-1:0] cnt;

  // Stage p0/p1: metastability synchronizer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      boton_p0 <= 1'b0;
      boton_p1 <= 1'b0;
    end else begin
      boton_p0 <= boton;
      boton_p1 <= boton_p0;
    end
  end

  // Debounce: the level flips on the DEBOUNCE_CYCLES-th consecutive mismatch,
  // so the counter tops out at DEBOUNCE_CYCLES-1 and cannot overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      nivel <= 1'b0;
      cnt   <= '0;
    end else if (boton_p1 == nivel) begin
      cnt <= '0;
    end else if (cnt == CNT_MAX) begin
      nivel <= boton_p1;
      cnt   <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // Stage p2: previous level for rising-edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) nivel_p2 <= 1'b0;
    else        nivel_p2 <= nivel;
  end

  assign pulso = nivel & ~nivel_p2;

endmodule

// File: rtl/alu_secuenciador_entrada.sv
// Operand-entry sequencer: loads A, B and the opcode from one switch bank on
// successive debounced button presses and flags the set valid once complete.
module alu_secuenciador_entrada
  import alu_secuenciador_pkg::*;
#(
  parameter int N               = 4,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] interruptores,
  input  logic         boton,
  output logic [N-1:0] entrada1,
  output logic [N-1:0] entrada2,
  output logic [3:0]   selector,
  output logic         valido,
  output logic [3:0]   estado_leds
);

  logic [N-1:0] sw_p0, sw_p1;
  logic         pulso;
  estado_t      estado, estado_sig;
  logic         carga_a, carga_b, carga_op;

  // Stage p0/p1: switch bank synchronizer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sw_p0 <= '0;
      sw_p1 <= '0;
    end else begin
      sw_p0 <= interruptores;
      sw_p1 <= sw_p0;
    end
  end

  antirrebote #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_antirrebote (
    .clk  (clk),
    .rst_n(rst_n),
    .boton(boton),
    .pulso(pulso)
  );

  // LEDs and valido are registered from the next state so they never glitch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado      <= CARGA_A;
      estado_leds <= LED_CARGA_A;
      valido      <= 1'b0;
    end else begin
      estado      <= estado_sig;
      estado_leds <= leds_de(estado_sig);
      valido      <= (estado_sig == MOSTRAR);
    end
  end

  always_comb begin
    estado_sig = estado;
    carga_a    = 1'b0;
    carga_b    = 1'b0;
    carga_op   = 1'b0;
    if (pulso) begin
      case (estado)
        CARGA_A:  begin carga_a  = 1'b1; estado_sig = CARGA_B;  end
        CARGA_B:  begin carga_b  = 1'b1; estado_sig = CARGA_OP; end
        CARGA_OP: begin carga_op = 1'b1; estado_sig = MOSTRAR;  end
        MOSTRAR:  estado_sig = CARGA_A;
        default:  estado_sig = CARGA_A;
      endcase
    end
  end

  // Unwritten registers hold, keeping the last result on the ALU while stale.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      entrada1 <= '0;
      entrada2 <= '0;
      selector <= '0;
    end else begin
      if (carga_a)  entrada1 <= sw_p1;
      if (carga_b)  entrada2 <= sw_p1;
      if (carga_op) selector <= sw_p1[3:0];
    end
  end

endmodule

// File: tb/tb_alu_secuenciador_entrada.sv
// Self-checking bench: vector table, timing corner cases and randomized
// presses checked against a press-counting reference model.
module tb_alu_secuenciador_entrada;

  localparam int N  = 4;
  localparam int DC = 4;

  logic         clk;
  logic         rst_n;
  logic [N-1:0] interruptores;
  logic         boton;
  logic [N-1:0] entrada1, entrada2;
  logic [3:0]   selector;
  logic         valido;
  logic [3:0]   estado_leds;

  int ntot  = 0;
  int npass = 0;

  alu_secuenciador_entrada #(.N(N), .DEBOUNCE_CYCLES(DC)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .interruptores(interruptores),
    .boton        (boton),
    .entrada1     (entrada1),
    .entrada2     (entrada2),
    .selector     (selector),
    .valido       (valido),
    .estado_leds  (estado_leds)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [3:0] sw;
    logic [3:0] e1;
    logic [3:0] e2;
    logic [3:0] sel;
    logic       val;
    logic [3:0] leds;
  } vec_t;

  vec_t tabla[8];

  // Reference model: operands as a function of the number of accepted presses
  int         m_st;
  logic [3:0] m_a, m_b, m_op;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    ntot++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic model_reset();
    m_st = 0; m_a = 4'h0; m_b = 4'h0; m_op = 4'h0;
  endtask

  task automatic model_press(input logic [3:0] sw);
    if (m_st == 0) m_a = sw;
    else if (m_st == 1) m_b = sw;
    else if (m_st == 2) m_op = sw;
    m_st = (m_st + 1) % 4;
  endtask

  task automatic chk_model(input string nm);
    chk({nm, "_e1"},   32'(entrada1),    32'(m_a));
    chk({nm, "_e2"},   32'(entrada2),    32'(m_b));
    chk({nm, "_sel"},  32'(selector),    32'(m_op));
    chk({nm, "_val"},  32'(valido),      32'(m_st == 3));
    chk({nm, "_leds"}, 32'(estado_leds), 32'(1 << m_st));
  endtask

  // Assert reset between clock edges and verify outputs clear without a clock
  task automatic do_reset();
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("rst_e1",   32'(entrada1),    32'h0);
    chk("rst_e2",   32'(entrada2),    32'h0);
    chk("rst_sel",  32'(selector),    32'h0);
    chk("rst_val",  32'(valido),      32'h0);
    chk("rst_leds", 32'(estado_leds), 32'h1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    model_reset();
  endtask

  // Set switches, press (with optional bounce on both edges), release.
  task automatic press(input logic [3:0] sw, input int hold, input int nb_p, input int nb_r);
    @(posedge clk);
    #1 interruptores = sw;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < nb_p; i++) begin
      boton = 1'b1;
      repeat ($urandom_range(1, 2)) @(posedge clk);
      #1 boton = 1'b0;
      repeat ($urandom_range(1, 2)) @(posedge clk);
      #1;
    end
    boton = 1'b1;
    repeat (hold) @(posedge clk);
    #1 boton = 1'b0;
    interruptores = 4'($urandom);
    for (int i = 0; i < nb_r; i++) begin
      repeat ($urandom_range(1, 2)) @(posedge clk);
      #1 boton = 1'b1;
      repeat ($urandom_range(1, 2)) @(posedge clk);
      #1 boton = 1'b0;
    end
    repeat (8) @(posedge clk);
    #1;
  endtask

  // Press once, changing switches right after edge k_change of the hold
  task automatic sw_timing(input int k_change, input logic [3:0] exp, input string nm);
    interruptores = 4'b0001;
    do_reset();
    repeat (4) @(posedge clk);
    #1 boton = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk);
      #1;
      if (k == k_change) interruptores = 4'b1110;
    end
    boton = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk(nm, 32'(entrada1), 32'(exp));
    chk({nm, "_leds"}, 32'(estado_leds), 32'h2);
  endtask

  initial begin
    int         cambios;
    logic [3:0] prev;
    logic [3:0] sw;

    rst_n = 1'b1;
    boton = 1'b0;
    interruptores = '0;
    model_reset();

    tabla[0] = '{4'h3, 4'h3, 4'h0, 4'h0, 1'b0, 4'b0010};
    tabla[1] = '{4'h5, 4'h3, 4'h5, 4'h0, 1'b0, 4'b0100};
    tabla[2] = '{4'h2, 4'h3, 4'h5, 4'h2, 1'b1, 4'b1000};
    tabla[3] = '{4'hF, 4'h3, 4'h5, 4'h2, 1'b0, 4'b0001};
    tabla[4] = '{4'h8, 4'h8, 4'h5, 4'h2, 1'b0, 4'b0010};
    tabla[5] = '{4'h6, 4'h8, 4'h6, 4'h2, 1'b0, 4'b0100};
    tabla[6] = '{4'hB, 4'h8, 4'h6, 4'hB, 1'b1, 4'b1000};
    tabla[7] = '{4'h0, 4'h8, 4'h6, 4'hB, 1'b0, 4'b0001};

    do_reset();

    // Table-driven full sequences
    for (int i = 0; i < 8; i++) begin
      press(tabla[i].sw, 10, 0, 0);
      chk($sformatf("tab%0d_e1", i),   32'(entrada1),    32'(tabla[i].e1));
      chk($sformatf("tab%0d_e2", i),   32'(entrada2),    32'(tabla[i].e2));
      chk($sformatf("tab%0d_sel", i),  32'(selector),    32'(tabla[i].sel));
      chk($sformatf("tab%0d_val", i),  32'(valido),      32'(tabla[i].val));
      chk($sformatf("tab%0d_leds", i), 32'(estado_leds), 32'(tabla[i].leds));
    end

    // Bounce rejection, then exact press latency
    do_reset();
    repeat (4) @(posedge clk);
    #1;
    cambios = 0;
    prev = estado_leds;
    for (int i = 0; i < 10; i++) begin
      boton = (i % 2 == 0);
      repeat (2) begin
        @(posedge clk);
        #1;
        if (estado_leds != prev) cambios++;
        prev = estado_leds;
      end
    end
    boton = 1'b0;
    chk("bounce_changes", 32'(cambios), 32'h0);
    chk("bounce_leds", 32'(estado_leds), 32'h1);
    boton = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk);
      #1;
      if (k == 5) chk("latency_edge5", 32'(estado_leds), 32'h1);
      if (k == 6) chk("latency_edge6", 32'(estado_leds), 32'h2);
    end
    boton = 1'b0;
    repeat (10) @(posedge clk);

    // Long hold gives exactly one advance
    do_reset();
    repeat (4) @(posedge clk);
    #1 boton = 1'b1;
    cambios = 0;
    prev = estado_leds;
    for (int k = 0; k < 220; k++) begin
      if (k == 200) boton = 1'b0;
      @(posedge clk);
      #1;
      if (estado_leds != prev) cambios++;
      prev = estado_leds;
    end
    chk("hold_changes", 32'(cambios), 32'h1);
    chk("hold_leds", 32'(estado_leds), 32'h2);

    // Switch capture versus synchronizer delay (pulse edge is edge 6)
    sw_timing(4, 4'b0001, "sw_late_old");
    sw_timing(2, 4'b1110, "sw_early_new");

    // Reset in the middle of a sequence
    do_reset();
    press(4'b1001, 10, 0, 0);
    press(4'b0110, 10, 0, 0);
    chk("mid_e1_before", 32'(entrada1), 32'h9);
    chk("mid_leds_before", 32'(estado_leds), 32'h4);
    do_reset();
    cambios = 0;
    prev = estado_leds;
    repeat (30) begin
      @(posedge clk);
      #1;
      if (estado_leds != prev) cambios++;
      prev = estado_leds;
    end
    chk("mid_after_changes", 32'(cambios), 32'h0);
    chk("mid_after_leds", 32'(estado_leds), 32'h1);
    chk("mid_after_e1", 32'(entrada1), 32'h0);

    // Randomized presses with bounce against the reference model
    do_reset();
    for (int i = 0; i < 30; i++) begin
      sw = 4'($urandom);
      press(sw, $urandom_range(8, 30), $urandom_range(0, 3), $urandom_range(0, 3));
      model_press(sw);
      chk_model($sformatf("rnd%0d", i));
    end

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule

// File: doc/alu_secuenciador_entrada.md
# alu_secuenciador_entrada

Operand-entry sequencer that sits directly upstream of the 4-bit ALU/display stage. It lets a user load operand A, operand B and the operation code one after another from one shared switch bank, using a single push-button. It debounces the button and steps a four-state FSM. It then presents stable `entrada1`, `entrada2` and `selector` registers to the ALU, with a `valido` flag that qualifies them.

## Interface
- `N`, default 4: operand width; must be ≥ 4 because `selector` is taken from `interruptores[3:0]`.
- `DEBOUNCE_CYCLES`, default 16: number of consecutive stable synchronized samples required to accept a button level change; must be ≥ 2.
- `clk`  input  1: single system clock; all state updates on its rising edge.
- `rst_n`  input  1: reset, asynchronous assert, active-low. One clock; reset is asynchronous and active-low.
- `interruptores`  input  N: raw switch bank; asynchronous to `clk`.
- `boton`  input  1: raw push-button, active-high, bouncy, asynchronous.
- `entrada1`  output  N: latched operand A.
- `entrada2`  output  N: latched operand B.
- `selector`  output  4: latched operation code.
- `valido`  output  1: high only in state MOSTRAR.
- `estado_leds`  output  4: one-hot current state, in the order CARGA_A=0001, CARGA_B=0010, CARGA_OP=0100, MOSTRAR=1000.

## Operation
- `boton` and `interruptores` each pass through a 2-flop synchronizer. All later logic uses only the synchronized values.
- Debounce:
  - Keep a debounced level `nivel` and a counter.
  - When the synchronized button equals `nivel`, clear the counter.
  - Otherwise increment the counter. When it reaches DEBOUNCE_CYCLES, set `nivel` to the synchronized value and clear the counter.
  - A mismatch shorter than DEBOUNCE_CYCLES leaves `nivel` unchanged.
- Pulse:
  - `pulso` is high for exactly one cycle, the cycle after `nivel` goes 0→1.
  - Holding the button gives exactly one pulse.
  - A release never produces a pulse.
- FSM actions on `pulso`, with switch values taken from the synchronized bus in that same cycle:
  - CARGA_A: `entrada1` ← `interruptores`; next state CARGA_B.
  - CARGA_B: `entrada2` ← `interruptores`; next state CARGA_OP.
  - CARGA_OP: `selector` ← `interruptores[3:0]`; next state MOSTRAR.
  - MOSTRAR: no register write; next state CARGA_A.
- Without `pulso`, state and all registers hold.
- Registers not written in the current state keep their previous values. The previous result therefore stays on the ALU while the next operation is being entered; `valido`=0 marks it as stale.
- `valido` and `estado_leds` are decoded from the state register and are glitch-free.

## Timing
- Reset values:
  - State CARGA_A.
  - `entrada1`=0, `entrada2`=0, `selector`=0, `valido`=0, `estado_leds`=0001.
  - `nivel`=0, counter=0, synchronizers=0.
- Press latency: let edge 0 be the first rising edge that samples `boton`=1 with no further bounce.
  - Synchronized value is high after edge 1.
  - `nivel` rises at edge 1+DEBOUNCE_CYCLES.
  - `pulso` is high during the following cycle.
  - Target register and state update at edge 2+DEBOUNCE_CYCLES. With the default, that is edge 18.
- Release needs DEBOUNCE_CYCLES stable low samples before another press can be accepted.
- If the button is held through reset deassertion, `nivel` restarts at 0. One pulse then follows DEBOUNCE_CYCLES+2 edges after deassertion, which is accepted behaviour.
- Reset asserted mid-sequence or mid-debounce returns everything to its reset values immediately, without waiting for a clock.
- Counter width is $clog2(DEBOUNCE_CYCLES+1) and must never overflow.

## Structure
- Package `alu_secuenciador_pkg`:
  - `typedef enum logic [1:0] {CARGA_A, CARGA_B, CARGA_OP, MOSTRAR} estado_t`.
  - One-hot LED constants for each state.
- Sub-module `antirrebote`, parameterised by DEBOUNCE_CYCLES:
  - Contains the button synchronizer, debounce counter and rising-edge detector.
  - Outputs `pulso`.
  - Instantiated once.
- Top level contains the switch synchronizer, FSM and output registers.

## Test plan
- Reset: drive `rst_n`=0 mid-clock. Outputs must go to 0/0/0, `valido`=0 and `estado_leds`=0001 asynchronously.
- Full sequence with DEBOUNCE_CYCLES=4: press with switches 0011, then 0101, then 0010, then one more press.
  - After the third press: `entrada1`=0011, `entrada2`=0101, `selector`=0010, `valido`=1, `estado_leds`=1000.
  - After the fourth press: state CARGA_A, `valido`=0, registers unchanged.
- Bounce rejection: toggle `boton` high/low every 2 cycles for 20 cycles with DEBOUNCE_CYCLES=4. Expect no state change. Then hold high: exactly one transition, at edge 6 after stable high.
- Long hold: keep `boton` high for 200 cycles. Expect exactly one state advance.
- Switch change timing: change switches 1 cycle before the pulse edge versus 3 cycles before. The captured value must reflect the 2-cycle synchronizer delay, i.e. the old value in the first case and the new value in the second.
- Reset mid-sequence: after loading A=1001 and while in CARGA_OP, assert `rst_n`. Expect all registers 0 and state CARGA_A, with no pulse generated on deassertion while the button is low.
